// File: rtl/machine_timer_unit.sv
// machine_timer_unit: memory-mapped mtime/mtimecmp/msip timer producing MTIP and MSIP
// Optional prescaler: define RAFI_TIMER_PRESCALE_EN to tick mtime every PRESCALE clocks.
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   req, we          one register access per asserted req cycle; we=1 write, we=0 read
//   addr[2:0]        0 msip, 1 mtimecmp lo, 2 mtimecmp hi, 3 mtime lo, 4 mtime hi, 5..7 unused
//   wdata[31:0]      write data
//   ack, rdata[31:0] response one cycle after req; rdata holds read data (0 for writes)
//   mtip, msip       timer / software interrupt pending to the CSR unit
module machine_timer_unit #(
    parameter int unsigned PRESCALE     = 1,
    parameter logic [63:0] MTIMECMP_RST = '1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        mtip,
    output logic        msip
);
    logic [63:0] mtime, mtime_n, mtimecmp, mtimecmp_n;
    logic [31:0] rd;
    logic        wr, wr_tlo, wr_thi, msip_n, tick;

    assign wr     = req && we;
    assign wr_tlo = wr && addr == 3'd3;
    assign wr_thi = wr && addr == 3'd4;

`ifdef RAFI_TIMER_PRESCALE_EN
    logic [15:0] pcnt;
    assign tick = pcnt == 16'(PRESCALE - 1);
    // A write to either mtime half restarts the prescale period.
    always_ff @(posedge clk) begin
        if (rst) pcnt <= '0;
        else     pcnt <= (wr_tlo || wr_thi || tick) ? '0 : pcnt + 16'd1;
    end
`else
    // PRESCALE is deliberately inert without the prescaler: tick every clock.
    assign tick = (PRESCALE != 0) | 1'b1;
`endif

    always_comb begin
        rd = addr == 3'd0 ? {31'b0, msip} :
             addr == 3'd1 ? mtimecmp[31:0] :
             addr == 3'd2 ? mtimecmp[63:32] :
             addr == 3'd3 ? mtime[31:0] :
             addr == 3'd4 ? mtime[63:32] : 32'b0;
        // A write beats a tick; the untouched half keeps its pre-tick value.
        mtime_n = wr_tlo ? {mtime[63:32], wdata} :
                  wr_thi ? {wdata, mtime[31:0]} :
                  tick   ? mtime + 64'd1 : mtime;
        mtimecmp_n = (wr && addr == 3'd1) ? {mtimecmp[63:32], wdata} :
                     (wr && addr == 3'd2) ? {wdata, mtimecmp[31:0]} : mtimecmp;
        msip_n = (wr && addr == 3'd0) ? wdata[0] : msip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime    <= '0;
            mtimecmp <= MTIMECMP_RST;
            msip     <= 1'b0;
            mtip     <= 1'b0;
            ack      <= 1'b0;
            rdata    <= '0;
        end else begin
            mtime    <= mtime_n;
            mtimecmp <= mtimecmp_n;
            msip     <= msip_n;
            // Compare current state, so mtip follows any change one cycle later.
            mtip     <= mtime >= mtimecmp;
            ack      <= req;
            rdata    <= (req && !we) ? rd : 32'b0;
        end
    end
endmodule

// File: tb/tb_machine_timer_unit.sv
// tb_machine_timer_unit: directed stimulus with a cycle-level reference model for machine_timer_unit
module tb_machine_timer_unit;
`ifdef RAFI_TIMER_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif
    localparam logic [63:0] CMP_RST = '1;

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        ack, mtip, msip;
    logic [31:0] rdata;

    int pass_cnt = 0, total = 0;

    machine_timer_unit #(.PRESCALE(P), .MTIMECMP_RST(CMP_RST)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .mtip(mtip), .msip(msip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: mtime is a base value plus elapsed whole prescale periods since it was last set.
    logic [63:0] base, cmp_m, m;
    int          cyc, t0;
    logic        msip_m, e_ack, e_mtip, e_msip, armed = 1'b0;
    logic [31:0] e_rdata;

    function automatic logic [31:0] rd_m(input logic [2:0] a, input logic [63:0] t);
        case (a)
            3'd0: return {31'b0, msip_m};
            3'd1: return cmp_m[31:0];
            3'd2: return cmp_m[63:32];
            3'd3: return t[31:0];
            3'd4: return t[63:32];
            default: return 32'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            base = '0; t0 = 0; cyc = 0; cmp_m = CMP_RST; msip_m = 1'b0;
            e_ack = 1'b0; e_rdata = '0; e_mtip = 1'b0; e_msip = 1'b0; armed = 1'b1;
        end else begin
            m = base + 64'((cyc - t0) / P);
            e_ack = req;
            e_rdata = (req && !we) ? rd_m(addr, m) : 32'b0;
            e_mtip = m >= cmp_m;
            if (req && we) begin
                case (addr)
                    3'd0: msip_m = wdata[0];
                    3'd1: cmp_m[31:0] = wdata;
                    3'd2: cmp_m[63:32] = wdata;
                    3'd3: begin base = {m[63:32], wdata}; t0 = cyc + 1; end
                    3'd4: begin base = {wdata, m[31:0]}; t0 = cyc + 1; end
                    default: ;
                endcase
            end
            e_msip = msip_m;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("ack", ack, e_ack);
            chk("rdata", rdata, e_rdata);
            chk("mtip", mtip, e_mtip);
            chk("msip", msip, e_msip);
        end
    end

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
        d = rdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    logic [31:0] d;
    int n;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
`ifndef RAFI_TIMER_PRESCALE_EN
        rd(3'd3, d); chk("mtime_c0", d, 0);
        rd(3'd3, d); chk("mtime_c1", d, 1);
        rd(3'd3, d); chk("mtime_c2", d, 2);
`endif
        repeat (1000) @(posedge clk);
        #1;
        wr(3'd0, 32'h1); chk("msip_out1", msip, 1);
        rd(3'd0, d); chk("msip_rd1", d, 1);
        wr(3'd0, 32'hFFFF_FFFE); chk("msip_out0", msip, 0);
        rd(3'd0, d); chk("msip_rd0", d, 0);
        wr(3'd3, 32'd5);
        wr(3'd2, 32'd0);
        wr(3'd1, 32'd20);
        n = 0;
        while (!mtip && n < 200) begin
            @(posedge clk); #1; n++;
        end
`ifndef RAFI_TIMER_PRESCALE_EN
        chk("mtip_rise_cycles", n, 14);
`else
        chk("mtip_rise_seen", mtip, 1);
`endif
        rd(3'd1, d); chk("cmp_lo", d, 20);
        rd(3'd2, d); chk("cmp_hi", d, 0);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd4, 32'hFFFF_FFFF);
`ifndef RAFI_TIMER_PRESCALE_EN
        rd(3'd3, d); chk("wrap_lo_max", d, 32'hFFFF_FFFF);
        rd(3'd3, d); chk("wrap_lo_zero", d, 0);
        rd(3'd4, d); chk("wrap_hi_zero", d, 0);
`else
        repeat (8) @(posedge clk);
        #1;
`endif
        repeat (30) @(posedge clk);
        #1;
        wr(3'd3, 32'd100);
        rd(3'd3, d); chk("write_during_tick", d, 100);
        wr(3'd5, 32'hDEAD_BEEF);
        rd(3'd5, d); chk("addr5_rd", d, 0);
        rd(3'd7, d); chk("addr7_rd", d, 0);
        repeat (2) @(posedge clk);
        #1;
        wr(3'd3, 32'd50);
        repeat (20) @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = 3'd3; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_drops_ack", ack, 0);
        rst = 1'b0; req = 1'b0;
        rd(3'd1, d); chk("cmp_after_rst", d, 32'hFFFF_FFFF);
`ifndef RAFI_TIMER_PRESCALE_EN
        rd(3'd3, d); chk("mtime_after_rst", d, 1);
`endif
        repeat (40) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
